player_shot_controller: RTL



---
 rtl/player_shot_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/player_shot_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_shot_controller
// Description : Owns up to four player projectiles. Spawns a shot on each
//               fire press (subject to a cooldown), moves live shots upward
//               once per game step, hit-tests them against the boss box and
//               emits one separated single-clock bossHit pulse per hit.
// Ports       : clk_master/rst         - clock, synchronous active-high reset
//               pulse_cycleStep        - one-clock game-step strobe
//               fire                   - debounced fire button level
//               playerLocX/Y           - player top-left position
//               bossLocX/Y, bossWidth/Height - boss bounding box
//               shot1..4 X/Y           - shot top-left, 0 when inactive
//               shotW/shotH            - constant shot size
//               shotActive             - bit i-1 set when shot i is live
//               bossHit                - one-clock pulse per registered hit
// Revision    : 1.0 - initial release
// ============================================================================
module player_shot_controller #(
  parameter int SHOT_W     = 4,
  parameter int SHOT_H     = 8,
  parameter int SHOT_SPEED = 4,
  parameter int PLAYER_W   = 32,
  parameter int COOLDOWN   = 3,
  parameter int SCREEN_W   = 640
) (
  input  logic       clk_master,
  input  logic       rst,
  input  logic       pulse_cycleStep,
  input  logic       fire,
  input  logic [9:0] playerLocX,
  input  logic [8:0] playerLocY,
  input  logic [9:0] bossLocX,
  input  logic [8:0] bossLocY,
  input  logic [9:0] bossWidth,
  input  logic [8:0] bossHeight,
  output logic [9:0] shot1X,
  output logic [8:0] shot1Y,
  output logic [9:0] shot2X,
  output logic [8:0] shot2Y,
  output logic [9:0] shot3X,
  output logic [8:0] shot3Y,
  output logic [9:0] shot4X,
  output logic [8:0] shot4Y,
  output logic [9:0] shotW,
  output logic [8:0] shotH,
  output logic [3:0] shotActive,
  output logic       bossHit
);

  localparam int             CD_W        = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] C_CD_LOAD  = CD_W'(COOLDOWN);
  localparam logic [10:0]    C_X_OFFS    = 11'(PLAYER_W / 2 - SHOT_W / 2);
  localparam logic [10:0]    C_X_MAX     = 11'(SCREEN_W - SHOT_W);
  localparam logic [8:0]     C_SHOT_H    = 9'(SHOT_H);
  localparam logic [8:0]     C_SPEED     = 9'(SHOT_SPEED);
  localparam logic [10:0]    C_SHOT_W11  = 11'(SHOT_W);
  localparam logic [10:0]    C_SHOT_H11  = 11'(SHOT_H);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_MOVE  = 2'd1,
    PH_CHECK = 2'd2
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [9:0]      x_q [4];
  logic [9:0]      x_d [4];
  logic [8:0]      y_q [4];
  logic [8:0]      y_d [4];
  logic [3:0]      act_q, act_d;
  logic            fire_q;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [2:0]      pend_q, pend_d;
  logic            hit_q, hit_d;

  logic            w_fire_rise;
  logic            w_spawn;
  logic            w_found;
  logic [10:0]     w_spawn_x11;
  logic [9:0]      w_spawn_x;
  logic [8:0]      w_spawn_y;
  logic [3:0]      w_overlap;
  logic [2:0]      w_add;
  logic [3:0]      w_pend_sum;

  assign w_fire_rise = fire & ~fire_q;
  assign w_spawn     = w_fire_rise && (cd_q == '0) && (act_q != 4'b1111);

  // Spawn centred on the player, clamped so the shot stays on screen.
  assign w_spawn_x11 = {1'b0, playerLocX} + C_X_OFFS;
  assign w_spawn_x   = (w_spawn_x11 > C_X_MAX) ? C_X_MAX[9:0] : w_spawn_x11[9:0];
  assign w_spawn_y   = (playerLocY < C_SHOT_H) ? 9'd0 : (playerLocY - C_SHOT_H);

  // Box overlap on the registered (already moved) positions, 11-bit compares.
  always_comb begin
    w_overlap = '0;
    for (int i = 0; i < 4; i++) begin
      w_overlap[i] = ({1'b0, x_q[i]} < ({1'b0, bossLocX} + {1'b0, bossWidth}))
                  && (({1'b0, x_q[i]} + C_SHOT_W11) > {1'b0, bossLocX})
                  && ({2'b0, y_q[i]} < ({2'b0, bossLocY} + {2'b0, bossHeight}))
                  && (({2'b0, y_q[i]} + C_SHOT_H11) > {2'b0, bossLocY});
    end
  end

  // Phase state register
  always_ff @(posedge clk_master) begin
    if (rst) begin
      phase_q <= PH_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase next-state: steps arriving outside IDLE are ignored.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:  if (pulse_cycleStep) phase_d = PH_MOVE;
      PH_MOVE:  phase_d = PH_CHECK;
      PH_CHECK: phase_d = PH_IDLE;
      default:  phase_d = PH_IDLE;
    endcase
  end

  // Shot slots, cooldown and pending-hit bookkeeping.
  always_comb begin
    act_d   = act_q;
    w_add   = '0;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end

    if (phase_q == PH_MOVE) begin
      for (int i = 0; i < 4; i++) begin
        if (act_q[i]) begin
          if (y_q[i] >= C_SPEED) begin
            y_d[i] = y_q[i] - C_SPEED;
          end else begin
            act_d[i] = 1'b0;
            x_d[i]   = '0;
            y_d[i]   = '0;
          end
        end
      end
    end

    if (phase_q == PH_CHECK) begin
      for (int i = 0; i < 4; i++) begin
        if (act_q[i] && w_overlap[i]) begin
          act_d[i] = 1'b0;
          x_d[i]   = '0;
          y_d[i]   = '0;
          w_add    = w_add + 3'd1;
        end
      end
    end

    // The spawn slot is free in act_q, so the move/check above never touched
    // it: a shot spawned during MOVE or CHECK sits out that step.
    if (w_spawn) begin
      for (int i = 0; i < 4; i++) begin
        if (!act_q[i] && !w_found) begin
          w_found  = 1'b1;
          act_d[i] = 1'b1;
          x_d[i]   = w_spawn_x;
          y_d[i]   = w_spawn_y;
        end
      end
    end

    cd_d = cd_q;
    if (w_spawn) begin
      cd_d = C_CD_LOAD;
    end else if (pulse_cycleStep && (cd_q != '0)) begin
      cd_d = cd_q - 1'b1;
    end

    // A pulse is only launched after a low clock, giving separated pulses.
    hit_d      = (pend_q != 3'd0) && !hit_q;
    w_pend_sum = {1'b0, pend_q} + {1'b0, w_add} - {3'b0, hit_d};
    pend_d     = (w_pend_sum > 4'd7) ? 3'd7 : w_pend_sum[2:0];
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      act_q  <= '0;
      fire_q <= 1'b0;
      cd_q   <= '0;
      pend_q <= '0;
      hit_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      act_q  <= act_d;
      fire_q <= fire;
      cd_q   <= cd_d;
      pend_q <= pend_d;
      hit_q  <= hit_d;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign shot1X     = x_q[0];
  assign shot1Y     = y_q[0];
  assign shot2X     = x_q[1];
  assign shot2Y     = y_q[1];
  assign shot3X     = x_q[2];
  assign shot3Y     = y_q[2];
  assign shot4X     = x_q[3];
  assign shot4Y     = y_q[3];
  assign shotW      = 10'(SHOT_W);
  assign shotH      = 9'(SHOT_H);
  assign shotActive = act_q;
  assign bossHit    = hit_q;

endmodule
`default_nettype wire
